// File: rtl/uart_debug_baud_ctrl.sv
// rtl/uart_debug_baud_ctrl.sv - debug-UART baud generator configuration sequencer
module uart_debug_baud_ctrl #(
    parameter int CLK_HZ   = 1843200,
    parameter int DEF_SEL  = 0,
    parameter int BUSY_TMO = 65535,
    parameter int HOLD_CYC = 2
) (
    input  logic        ref_clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic [2:0]  cfg_sel,
    input  logic        uart_busy,
    input  logic        baud_tick,
    output logic [15:0] period_cnt,
    output logic        baud_gen_rst_n,
    output logic        baud_ready,
    output logic        cfg_ack,
    output logic        cfg_err
);

    function automatic logic [15:0] period_of(input longint rate);
        longint q;
        q = longint'(CLK_HZ) / rate - 1;
        if (q > 65535) return 16'hFFFF;
        if (q < 1) return 16'd1;
        return q[15:0];
    endfunction

    localparam logic [15:0] PER_0 = period_of(9600);
    localparam logic [15:0] PER_1 = period_of(19200);
    localparam logic [15:0] PER_2 = period_of(38400);
    localparam logic [15:0] PER_3 = period_of(57600);
    localparam logic [15:0] PER_4 = period_of(115200);
    localparam logic [15:0] PER_5 = period_of(230400);

    localparam logic [2:0]  DEF_SEL_3 = 3'(DEF_SEL);
    localparam logic [15:0] BUSY_LIM  = 16'(BUSY_TMO);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    function automatic logic [15:0] period_lookup(input logic [2:0] sel);
        case (sel)
            3'd1:    return PER_1;
            3'd2:    return PER_2;
            3'd3:    return PER_3;
            3'd4:    return PER_4;
            3'd5:    return PER_5;
            default: return PER_0;
        endcase
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_HOLD, S_SYNC, S_ACK, S_WAIT_REL
    } state_t;

    state_t      state;
    logic [2:0]  sel_q;
    logic [15:0] wait_cnt;
    logic [15:0] hold_cnt;
    logic [16:0] sync_cnt;
    logic        boot;
    logic        err_q;

    // boot marks the post-reset DEF_SEL bring-up, which finishes without an ack
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HOLD;
            sel_q          <= DEF_SEL_3;
            wait_cnt       <= '0;
            hold_cnt       <= '0;
            sync_cnt       <= '0;
            boot           <= 1'b1;
            err_q          <= 1'b0;
            period_cnt     <= period_lookup(DEF_SEL_3);
            baud_gen_rst_n <= 1'b0;
            baud_ready     <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_req) begin
                        if (cfg_sel > 3'd5) begin
                            err_q <= 1'b1;
                            state <= S_ACK;
                        end else begin
                            sel_q    <= cfg_sel;
                            err_q    <= 1'b0;
                            wait_cnt <= 16'd1;
                            state    <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (!uart_busy) begin
                        period_cnt     <= period_lookup(sel_q);
                        baud_gen_rst_n <= 1'b0;
                        baud_ready     <= 1'b0;
                        hold_cnt       <= '0;
                        state          <= S_HOLD;
                    end else if (wait_cnt >= BUSY_LIM) begin
                        err_q <= 1'b1;
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        baud_gen_rst_n <= 1'b1;
                        sync_cnt       <= 17'd1;
                        state          <= S_SYNC;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                S_SYNC: begin
                    // sync_cnt counts cycles since release, including the current one
                    if (baud_tick) begin
                        baud_ready <= 1'b1;
                        err_q      <= 1'b0;
                        boot       <= 1'b0;
                        state      <= boot ? S_IDLE : S_ACK;
                    end else if (sync_cnt >= {1'b0, period_cnt} + 17'd4) begin
                        baud_gen_rst_n <= 1'b0;
                        baud_ready     <= 1'b0;
                        err_q          <= 1'b1;
                        boot           <= 1'b0;
                        state          <= boot ? S_IDLE : S_ACK;
                    end else begin
                        sync_cnt <= sync_cnt + 17'd1;
                    end
                end
                S_ACK: begin
                    cfg_ack <= 1'b1;
                    cfg_err <= err_q;
                    state   <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!cfg_req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_baud_ctrl.sv
// tb/tb_uart_debug_baud_ctrl.sv - self-checking bench for uart_debug_baud_ctrl
module tb_uart_debug_baud_ctrl;
    localparam int CLK_HZ   = 1843200;
    localparam int HOLD_CYC = 2;
    localparam int TMO_T    = 50;

    logic        ref_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic [2:0]  cfg_sel = 3'd0;
    logic        uart_busy = 1'b0;
    logic        baud_tick;
    logic [15:0] period_cnt;
    logic        baud_gen_rst_n, baud_ready, cfg_ack, cfg_err;

    logic        req_t = 1'b0, busy_t = 1'b0, tick_t;
    logic [15:0] period_t;
    logic        gen_t, ready_t, ack_t, err_t;

    logic        tick_en = 1'b1;
    int          gcnt = 0, gcnt_t = 0;
    int          chk_cnt = 0, pass_cnt = 0;
    int          rates [6] = '{9600, 19200, 38400, 57600, 115200, 230400};

    uart_debug_baud_ctrl #(.CLK_HZ(CLK_HZ), .DEF_SEL(0), .BUSY_TMO(65535), .HOLD_CYC(HOLD_CYC)) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .uart_busy(uart_busy), .baud_tick(baud_tick), .period_cnt(period_cnt),
        .baud_gen_rst_n(baud_gen_rst_n), .baud_ready(baud_ready), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
    );

    uart_debug_baud_ctrl #(.CLK_HZ(CLK_HZ), .DEF_SEL(0), .BUSY_TMO(TMO_T), .HOLD_CYC(HOLD_CYC)) dut_t (
        .ref_clk(ref_clk), .rst_n(rst_n), .cfg_req(req_t), .cfg_sel(cfg_sel),
        .uart_busy(busy_t), .baud_tick(tick_t), .period_cnt(period_t),
        .baud_gen_rst_n(gen_t), .baud_ready(ready_t), .cfg_ack(ack_t), .cfg_err(err_t)
    );

    always #5 ref_clk = ~ref_clk;

    // Baud generator stand-ins: tick every period+1 cycles after release
    always @(posedge ref_clk) begin
        if (!baud_gen_rst_n || gcnt == int'(period_cnt)) gcnt <= 0; else gcnt <= gcnt + 1;
        if (!gen_t || gcnt_t == int'(period_t)) gcnt_t <= 0; else gcnt_t <= gcnt_t + 1;
    end
    assign baud_tick = tick_en && baud_gen_rst_n && (gcnt == int'(period_cnt));
    assign tick_t    = gen_t && (gcnt_t == int'(period_t));

    function automatic int exp_period(input int sel);
        int q;
        q = CLK_HZ / rates[sel] - 1;
        if (q > 65535) q = 65535;
        if (q < 1) q = 1;
        return q;
    endfunction

    // IDLE + WAIT_IDLE cycles + hold + (period+1) until first tick + ACK
    function automatic int exp_lat(input int sel, input int b);
        return 1 + ((b > 1) ? b : 1) + HOLD_CYC + exp_period(sel) + 1 + 1;
    endfunction

    task automatic cyc;
        @(posedge ref_clk);
        #1;
    endtask

    task automatic do_req(input logic [2:0] sel, input int b, output int n_ack, output logic err,
                          output int n_per, output logic busy_ok);
        logic [15:0] old;
        old = period_cnt; n_ack = 0; n_per = 0; busy_ok = 1'b1; err = 1'b0;
        cfg_sel = sel; cfg_req = 1'b1; uart_busy = (b > 0);
        for (int n = 1; n <= 600; n++) begin
            cyc;
            if (n == 1) cfg_sel = 3'($urandom);
            if (n_per == 0 && period_cnt !== old) n_per = n;
            if (n <= b && !(baud_gen_rst_n && baud_ready)) busy_ok = 1'b0;
            if (n == b) uart_busy = 1'b0;
            if (cfg_ack) begin n_ack = n; err = cfg_err; break; end
        end
        uart_busy = 1'b0; cfg_req = 1'b0;
        cyc; cyc;
    endtask

    task automatic test_reset;
        int n_rdy, acks;
        rst_n = 1'b0; cfg_req = 1'b0; uart_busy = 1'b0; req_t = 1'b0; busy_t = 1'b0; tick_en = 1'b1;
        repeat (3) cyc;
        chk_cnt++; if (int'(period_cnt) !== exp_period(0)) $display("FAIL rst_period got %0d want %0d", period_cnt, exp_period(0)); else pass_cnt++;
        chk_cnt++; if (baud_gen_rst_n !== 1'b0) $display("FAIL rst_genrst got %b want 0", baud_gen_rst_n); else pass_cnt++;
        chk_cnt++; if (baud_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", baud_ready); else pass_cnt++;
        chk_cnt++; if ({cfg_ack, cfg_err} !== 2'b00) $display("FAIL rst_ack got %b want 00", {cfg_ack, cfg_err}); else pass_cnt++;
        rst_n = 1'b1; n_rdy = 0; acks = 0;
        for (int n = 1; n <= 240; n++) begin
            cyc;
            if (n == 1) begin
                chk_cnt++; if (baud_gen_rst_n !== 1'b0) $display("FAIL boot_hold1 got %b want 0", baud_gen_rst_n); else pass_cnt++;
            end
            if (n == 2) begin
                chk_cnt++; if (baud_gen_rst_n !== 1'b1) $display("FAIL boot_release got %b want 1", baud_gen_rst_n); else pass_cnt++;
            end
            if (cfg_ack) acks++;
            if (baud_ready && n_rdy == 0) n_rdy = n;
        end
        chk_cnt++; if (n_rdy !== HOLD_CYC + exp_period(0) + 1) $display("FAIL boot_ready_cycle got %0d want %0d", n_rdy, HOLD_CYC + exp_period(0) + 1); else pass_cnt++;
        chk_cnt++; if (acks !== 0) $display("FAIL boot_no_ack got %0d want 0", acks); else pass_cnt++;
        chk_cnt++; if (ready_t !== 1'b1) $display("FAIL boot_ready_t got %b want 1", ready_t); else pass_cnt++;
    endtask

    task automatic test_rate_change;
        int n_ack, n_per; logic err, bok;
        do_req(3'd4, 0, n_ack, err, n_per, bok);
        chk_cnt++; if (n_ack !== exp_lat(4, 0)) $display("FAIL sel4_lat got %0d want %0d", n_ack, exp_lat(4, 0)); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL sel4_err got %b want 0", err); else pass_cnt++;
        chk_cnt++; if (int'(period_cnt) !== 15) $display("FAIL sel4_period got %0d want 15", period_cnt); else pass_cnt++;
        chk_cnt++; if (n_per !== 2) $display("FAIL sel4_load_cycle got %0d want 2", n_per); else pass_cnt++;
        chk_cnt++; if ({baud_ready, baud_gen_rst_n} !== 2'b11) $display("FAIL sel4_running got %b want 11", {baud_ready, baud_gen_rst_n}); else pass_cnt++;
    endtask

    task automatic test_illegal;
        int n_ack, n_per; logic err, bok; logic [15:0] old_p; logic old_r;
        for (int s = 6; s <= 7; s++) begin
            old_p = period_cnt; old_r = baud_ready;
            do_req(3'(s), 0, n_ack, err, n_per, bok);
            chk_cnt++; if (n_ack !== 2) $display("FAIL illegal%0d_lat got %0d want 2", s, n_ack); else pass_cnt++;
            chk_cnt++; if (err !== 1'b1) $display("FAIL illegal%0d_err got %b want 1", s, err); else pass_cnt++;
            chk_cnt++; if ({period_cnt, baud_ready} !== {old_p, old_r}) $display("FAIL illegal%0d_untouched got %0d/%b want %0d/%b", s, period_cnt, baud_ready, old_p, old_r); else pass_cnt++;
        end
    endtask

    task automatic test_busy;
        int n_ack, n_per, n_t; logic err, bok, e_t;
        do_req(3'd1, 100, n_ack, err, n_per, bok);
        chk_cnt++; if (bok !== 1'b1) $display("FAIL busy_old_running got %b want 1", bok); else pass_cnt++;
        chk_cnt++; if (n_per !== 101) $display("FAIL busy_load_cycle got %0d want 101", n_per); else pass_cnt++;
        chk_cnt++; if (n_ack !== exp_lat(1, 100)) $display("FAIL busy_lat got %0d want %0d", n_ack, exp_lat(1, 100)); else pass_cnt++;
        chk_cnt++; if (int'(period_cnt) !== 95 || err !== 1'b0) $display("FAIL busy_result got %0d/%b want 95/0", period_cnt, err); else pass_cnt++;
        cfg_sel = 3'd1; req_t = 1'b1; busy_t = 1'b1; n_t = 0; e_t = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            cyc;
            if (ack_t) begin n_t = n; e_t = err_t; break; end
        end
        req_t = 1'b0; busy_t = 1'b0; cyc; cyc;
        chk_cnt++; if (n_t !== TMO_T + 2) $display("FAIL tmo_lat got %0d want %0d", n_t, TMO_T + 2); else pass_cnt++;
        chk_cnt++; if (e_t !== 1'b1) $display("FAIL tmo_err got %b want 1", e_t); else pass_cnt++;
        chk_cnt++; if ({period_t, ready_t} !== {16'(exp_period(0)), 1'b1}) $display("FAIL tmo_untouched got %0d/%b want %0d/1", period_t, ready_t, exp_period(0)); else pass_cnt++;
    endtask

    task automatic test_sync_fail;
        int n_ack, n_per; logic err, bok;
        tick_en = 1'b0;
        do_req(3'd5, 0, n_ack, err, n_per, bok);
        tick_en = 1'b1;
        // release lands 1+1+HOLD_CYC cycles in; failure acked period+4 SYNC cycles later plus ACK
        chk_cnt++; if (n_ack !== 1 + 1 + HOLD_CYC + exp_period(5) + 4 + 1) $display("FAIL syncfail_lat got %0d want %0d", n_ack, 1 + 1 + HOLD_CYC + exp_period(5) + 5); else pass_cnt++;
        chk_cnt++; if (err !== 1'b1) $display("FAIL syncfail_err got %b want 1", err); else pass_cnt++;
        chk_cnt++; if ({baud_ready, baud_gen_rst_n} !== 2'b00) $display("FAIL syncfail_held got %b want 00", {baud_ready, baud_gen_rst_n}); else pass_cnt++;
        do_req(3'd5, 0, n_ack, err, n_per, bok);
        chk_cnt++; if (n_ack !== exp_lat(5, 0) || err !== 1'b0) $display("FAIL recover got %0d/%b want %0d/0", n_ack, err, exp_lat(5, 0)); else pass_cnt++;
        chk_cnt++; if ({baud_ready, baud_gen_rst_n} !== 2'b11) $display("FAIL recover_running got %b want 11", {baud_ready, baud_gen_rst_n}); else pass_cnt++;
    endtask

    task automatic test_random;
        int n_ack, n_per, sel, b, exp_p; logic err, bok;
        for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 7); b = $urandom_range(0, 12);
            exp_p = (sel > 5) ? int'(period_cnt) : exp_period(sel);
            do_req(3'(sel), b, n_ack, err, n_per, bok);
            if (sel > 5) begin
                chk_cnt++; if (n_ack !== 2 || err !== 1'b1) $display("FAIL rand%0d_sel%0d got %0d/%b want 2/1", i, sel, n_ack, err); else pass_cnt++;
            end else begin
                chk_cnt++; if (n_ack !== exp_lat(sel, b) || err !== 1'b0) $display("FAIL rand%0d_sel%0d got %0d/%b want %0d/0", i, sel, n_ack, err, exp_lat(sel, b)); else pass_cnt++;
            end
            chk_cnt++; if (int'(period_cnt) !== exp_p) $display("FAIL rand%0d_period got %0d want %0d", i, period_cnt, exp_p); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        acks = 0; cfg_sel = 3'd2; cfg_req = 1'b1;
        for (int n = 1; n <= exp_lat(2, 0) + 20; n++) begin
            cyc;
            if (cfg_ack) acks++;
        end
        cfg_req = 1'b0;
        repeat (5) begin cyc; if (cfg_ack) acks++; end
        chk_cnt++; if (acks !== 1) $display("FAIL held_req_acks got %0d want 1", acks); else pass_cnt++;
        chk_cnt++; if (int'(period_cnt) !== exp_period(2)) $display("FAIL held_req_period got %0d want %0d", period_cnt, exp_period(2)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sync;
        int acks;
        acks = 0; cfg_sel = 3'd3; cfg_req = 1'b1;
        // HOLD entry at 2, release at 2+HOLD_CYC; reset a few cycles into SYNC
        for (int n = 1; n <= 2 + HOLD_CYC + 5; n++) begin
            cyc;
            if (cfg_ack) acks++;
        end
        chk_cnt++; if (baud_gen_rst_n !== 1'b1 || int'(period_cnt) !== exp_period(3)) $display("FAIL midsync_state got %b/%0d want 1/%0d", baud_gen_rst_n, period_cnt, exp_period(3)); else pass_cnt++;
        rst_n = 1'b0; cfg_req = 1'b0;
        #1;
        chk_cnt++; if ({cfg_ack, baud_ready, baud_gen_rst_n} !== 3'b000 || acks !== 0) $display("FAIL midsync_abort got %b acks %0d want 000 acks 0", {cfg_ack, baud_ready, baud_gen_rst_n}, acks); else pass_cnt++;
        test_reset();
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_illegal();
        test_busy();
        test_sync_fail();
        test_random();
        test_back_to_back();
        test_reset_mid_sync();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
